// File: rtl/line_mem_ctrl.sv
// Line-granular main-memory model and controller for the data cache refill/write-back path.
// Optional burst statistics counters are enabled by defining LINE_MEM_STAT_EN.
module line_mem_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 13,
  parameter int MEM_ADDR_LEN  = 10,
  parameter int LATENCY       = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               rd_req_i,
  input  logic                               wr_req_i,
  input  logic [ADDR_LEN-1:0]                addr_i,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]   wr_line_i,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]   rd_line_o,
  output logic                               gnt_o,
  output logic                               busy_o
`ifdef LINE_MEM_STAT_EN
  ,
  output logic [31:0]                        rd_burst_cnt_o,
  output logic [31:0]                        wr_burst_cnt_o,
  output logic [31:0]                        busy_cycle_cnt_o
`endif
);

  localparam int LineBits = 32 * (2 ** LINE_ADDR_LEN);
  localparam int MemLines = 2 ** MEM_ADDR_LEN;
  localparam logic [7:0] CntInit = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                    state_q;
  logic [7:0]                cnt_q;
  logic                      op_wr_q;
  logic [MEM_ADDR_LEN-1:0]   addr_q;
  logic [LineBits-1:0]       wr_line_q;
  logic [LineBits-1:0]       rd_line_q;
  logic                      gnt_q;
  logic                      commit_d;
  logic                      unused_addr_bits;

  logic [LineBits-1:0]       mem_q [MemLines];

  // Upper line-address bits alias onto the physically backed lines.
  assign unused_addr_bits = ^addr_i[ADDR_LEN-1:MEM_ADDR_LEN];

  assign commit_d  = (state_q == BUSY) && (cnt_q == 8'd0);
  assign rd_line_o = rd_line_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
      gnt_q     <= 1'b0;
    end else begin
      gnt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req_i || wr_req_i) begin
            op_wr_q   <= wr_req_i;
            addr_q    <= addr_i[MEM_ADDR_LEN-1:0];
            wr_line_q <= wr_line_i;
            cnt_q     <= CntInit;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            if (!op_wr_q) begin
              rd_line_q <= mem_q[addr_q];
            end
            gnt_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a reset mid-burst drops the pending commit.
  always_ff @(posedge clk_i) begin
    if (commit_d && op_wr_q) begin
      mem_q[addr_q] <= wr_line_q;
    end
  end

`ifdef LINE_MEM_STAT_EN
  logic [31:0] rd_burst_cnt_q;
  logic [31:0] wr_burst_cnt_q;
  logic [31:0] busy_cycle_cnt_q;

  assign rd_burst_cnt_o   = rd_burst_cnt_q;
  assign wr_burst_cnt_o   = wr_burst_cnt_q;
  assign busy_cycle_cnt_o = busy_cycle_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_burst_cnt_q   <= 32'd0;
      wr_burst_cnt_q   <= 32'd0;
      busy_cycle_cnt_q <= 32'd0;
    end else begin
      if (gnt_q && !op_wr_q) begin
        rd_burst_cnt_q <= rd_burst_cnt_q + 32'd1;
      end
      if (gnt_q && op_wr_q) begin
        wr_burst_cnt_q <= wr_burst_cnt_q + 32'd1;
      end
      if (busy_o) begin
        busy_cycle_cnt_q <= busy_cycle_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule
